// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream to 32-bit instruction-memory loader
module instruction_loader #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        overrun,
    output logic [31:0] word_count
);

    // Byte address of the final word slot; a non-halt word written here ends the session.
    localparam logic [31:0] LAST_ADDR = 32'((MEM_WORDS - 1) * 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] asm_q, asm_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] wc_q, wc_d;
    logic        ovf_q, ovf_d;
    logic        ovr_q, ovr_d;
    logic        wr_en_q, busy_q, done_q;

    // Next-state and datapath updates; every register holds unless a rule below changes it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        wc_d    = wc_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A start opens a fresh session; any byte in the same cycle is discarded.
                if (start) begin
                    state_d = S_RECV;
                    addr_d  = '0;
                    asm_d   = '0;
                    cnt_d   = '0;
                    wc_d    = '0;
                    ovf_d   = 1'b0;
                    ovr_d   = 1'b0;
                end
            end
            S_RECV: begin
                if (byte_valid) begin
                    asm_d = {asm_q[23:0], byte_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The write slot cannot accept a byte; flag it and let it fall on the floor.
                if (byte_valid) begin
                    ovr_d = 1'b1;
                end
                wc_d   = wc_q + 32'd1;
                addr_d = addr_q + 32'd4;
                cnt_d  = '0;
                if (asm_q == HALT_WORD) begin
                    state_d = S_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; status flags are derived from the next state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
            wr_en_q <= (state_d == S_WRITE);
            busy_q  <= (state_d == S_RECV) || (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = asm_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign overrun    = ovr_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - random and directed checks of instruction_loader against a session model
module tb_instruction_loader;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;

    logic [1:0]  o_wr_en, o_busy, o_done, o_ovf, o_ovr;
    logic [31:0] o_addr [2];
    logic [31:0] o_data [2];
    logic [31:0] o_wc   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instruction_loader u_dut_a (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .wr_en(o_wr_en[0]), .wr_addr(o_addr[0]), .wr_data(o_data[0]), .busy(o_busy[0]),
        .done(o_done[0]), .overflow(o_ovf[0]), .overrun(o_ovr[0]), .word_count(o_wc[0])
    );

    instruction_loader #(.MEM_WORDS(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .wr_en(o_wr_en[1]), .wr_addr(o_addr[1]), .wr_data(o_data[1]), .busy(o_busy[1]),
        .done(o_done[1]), .overflow(o_ovf[1]), .overrun(o_ovr[1]), .word_count(o_wc[1])
    );

    // Session model: a session collects bytes into words; a word costs one write cycle;
    // the session ends on the halt word or when the memory has been filled.
    int unsigned mem_words [2] = '{256, 4};
    bit          m_act [2];
    bit          m_wr  [2];
    bit          m_end [2];
    bit          m_ovf [2];
    bit          m_ovr [2];
    int unsigned m_cnt [2];
    int unsigned m_nb  [2];
    logic [31:0] m_acc [2];
    logic [31:0] m_word[2];

    task automatic m_clear(input int k);
        m_act[k] = 0; m_wr[k] = 0; m_end[k] = 0; m_ovf[k] = 0; m_ovr[k] = 0;
        m_cnt[k] = 0; m_nb[k] = 0; m_acc[k] = 32'h0; m_word[k] = 32'h0;
    endtask

    task automatic m_step(input int k);
        if (m_wr[k]) begin
            if (byte_valid) m_ovr[k] = 1;
            m_wr[k]  = 0;
            m_cnt[k] = m_cnt[k] + 1;
            m_nb[k]  = 0;
            m_acc[k] = 32'h0;
            if (m_word[k] == HALT) begin
                m_act[k] = 0; m_end[k] = 1;
            end else if (m_cnt[k] == mem_words[k]) begin
                m_ovf[k] = 1; m_act[k] = 0; m_end[k] = 1;
            end
        end else if (m_act[k]) begin
            if (byte_valid) begin
                m_acc[k] = m_acc[k] * 256 + {24'h0, byte_data};
                m_nb[k]  = m_nb[k] + 1;
                if (m_nb[k] == 4) begin
                    m_word[k] = m_acc[k];
                    m_wr[k]   = 1;
                end
            end
        end else if (start) begin
            m_act[k] = 1; m_end[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_ovr[k] = 0;
            m_nb[k] = 0; m_acc[k] = 32'h0;
        end
    endtask

    // Advance the model on every clock edge; reset clears it immediately.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clear(0);
            m_clear(1);
        end else begin
            m_step(0);
            m_step(1);
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[dut%0d] got=%h expected=%h at %0t", name, k, got, exp, $time);
    endtask

    // Compare both instances to the model away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("wr_en", k, {31'h0, o_wr_en[k]}, {31'h0, m_wr[k]});
            chk("busy", k, {31'h0, o_busy[k]}, {31'h0, m_act[k]});
            chk("done", k, {31'h0, o_done[k]}, {31'h0, m_end[k]});
            chk("overflow", k, {31'h0, o_ovf[k]}, {31'h0, m_ovf[k]});
            chk("overrun", k, {31'h0, o_ovr[k]}, {31'h0, m_ovr[k]});
            chk("word_count", k, o_wc[k], m_cnt[k]);
            if (m_wr[k]) begin
                chk("wr_addr", k, o_addr[k], m_cnt[k] * 4);
                chk("wr_data", k, o_data[k], m_word[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        cyc();
        byte_valid = 1'b0;
    endtask

    // Four bytes big-endian; returns in the write cycle of that word.
    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        cyc();
        chk("rst_wr_en", 0, {31'h0, o_wr_en[0]}, 32'h0);
        chk("rst_busy", 0, {31'h0, o_busy[0]}, 32'h0);
        chk("rst_wc", 1, o_wc[1], 32'h0);
        reset = 1'b0;
        cyc();

        // Basic load
        pulse_start();
        send_word(32'h20080005);
        chk("basic_wr_en", 0, {31'h0, o_wr_en[0]}, 32'h1);
        chk("basic_addr", 0, o_addr[0], 32'h0);
        chk("basic_data", 0, o_data[0], 32'h20080005);
        cyc();
        chk("basic_wc", 0, o_wc[0], 32'd1);
        chk("basic_busy", 0, {31'h0, o_busy[0]}, 32'h1);

        // Halt after three words
        send_word(32'h11223344); cyc();
        send_word(32'h55667788); cyc();
        send_word(HALT);
        chk("halt_addr", 0, o_addr[0], 32'd12);
        chk("halt_data", 0, o_data[0], HALT);
        cyc();
        chk("halt_done", 0, {31'h0, o_done[0]}, 32'h1);
        chk("halt_busy", 0, {31'h0, o_busy[0]}, 32'h0);
        chk("halt_wc", 0, o_wc[0], 32'd4);
        chk("halt_last_slot_no_ovf", 1, {31'h0, o_ovf[1]}, 32'h0);

        // Overflow on the four-word instance
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_word(32'h10000000 + i);
            cyc();
        end
        chk("ovf_flag", 1, {31'h0, o_ovf[1]}, 32'h1);
        chk("ovf_done", 1, {31'h0, o_done[1]}, 32'h1);
        chk("ovf_wc", 1, o_wc[1], 32'd4);
        send_word(32'hABCD0123);
        chk("ovf_no_write", 1, {31'h0, o_wr_en[1]}, 32'h0);
        chk("deep_write", 0, o_addr[0], 32'd16);
        cyc();

        // Overrun during the write cycle
        reset_pulse();
        pulse_start();
        send_word(32'hA1A2A3A4);
        send_byte(8'hEE);
        chk("overrun_flag", 0, {31'h0, o_ovr[0]}, 32'h1);
        send_word(32'h01020304);
        chk("overrun_addr", 0, o_addr[0], 32'd4);
        chk("overrun_data", 0, o_data[0], 32'h01020304);
        cyc();

        // Reset in the middle of a word
        reset_pulse();
        pulse_start();
        send_byte(8'h99);
        send_byte(8'h88);
        reset = 1'b1;
        #2;
        chk("midrst_busy", 0, {31'h0, o_busy[0]}, 32'h0);
        chk("midrst_data", 0, o_data[0], 32'h0);
        reset = 1'b0;
        cyc();
        pulse_start();
        send_word(32'h5A6B7C8D);
        chk("midrst_addr", 0, o_addr[0], 32'h0);
        chk("midrst_newdata", 0, o_data[0], 32'h5A6B7C8D);
        cyc();

        // Restart after done, with stray starts while busy
        send_word(HALT);
        cyc();
        pulse_start();
        send_byte(8'h12);
        pulse_start();
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        chk("restart_addr", 0, o_addr[0], 32'h0);
        chk("restart_data", 0, o_data[0], 32'h12345678);
        cyc();
        chk("restart_done", 0, {31'h0, o_done[0]}, 32'h0);
        chk("restart_wc", 0, o_wc[0], 32'd1);
        pulse_start();
        send_word(32'hCAFEF00D);
        chk("busy_start_addr", 0, o_addr[0], 32'd4);
        cyc();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            start      = ($urandom_range(0, 15) == 0);
            byte_valid = $urandom_range(0, 1) == 1;
            byte_data  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            reset      = ($urandom_range(0, 499) == 0);
            cyc();
        end
        start = 1'b0;
        byte_valid = 1'b0;
        reset = 1'b0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, the end-of-program marker.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load session.
REQ-006 The block SHALL have port byte_valid, input, 1 bit: byte_data is valid this cycle (one-cycle strobe per byte).
REQ-007 The block SHALL have port byte_data, input, 8 bits: incoming program byte.
REQ-008 The block SHALL have port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port wr_addr, output, 32 bits: byte address of the write, word-aligned.
REQ-010 The block SHALL have port wr_data, output, 32 bits: instruction word to write.
REQ-011 The block SHALL have port busy, output, 1 bit: a session is in progress (RECV or WRITE).
REQ-012 The block SHALL have port done, output, 1 bit: the session has ended; held high until the next start or reset.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky; the program exceeded MEM_WORDS.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky; a byte arrived while in WRITE and was dropped.
REQ-015 The block SHALL have port word_count, output, 32 bits: number of words written in the current session.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, RECV, WRITE and DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE, start SHALL move the FSM to RECV on the next edge and, on that same edge, clear: write address, byte counter, assembly register, word_count, done, overflow and overrun.
REQ-018 In RECV, each byte_valid SHALL shift the byte in big-endian order (assembly = {assembly[23:0], byte_data}) and increment a 2-bit byte counter.
REQ-019 When the 4th byte of a word is accepted, the FSM SHALL enter WRITE on that edge.
REQ-020 In WRITE, wr_en SHALL be high for exactly one cycle, with wr_addr = current address and wr_data = assembled word; wr_en SHALL therefore assert in the cycle after the 4th byte_valid.
REQ-021 On leaving WRITE, word_count SHALL increment by 1 and the address SHALL increment by 4.
REQ-022 If the written word equals HALT_WORD, it SHALL still be written, and the FSM SHALL then go to DONE.
REQ-023 If a non-halt word is written at the last address ((MEM_WORDS-1)*4), the FSM SHALL set overflow and go to DONE.
REQ-024 Otherwise, after WRITE the FSM SHALL return to RECV with the byte counter at 0.
REQ-025 byte_valid in WRITE SHALL be dropped (not shifted in) and SHALL set overrun.
REQ-026 byte_valid in IDLE or DONE SHALL be ignored without setting any flag.
REQ-027 start while busy SHALL be ignored.
REQ-028 start and byte_valid in the same IDLE cycle: start SHALL be taken and the byte discarded.
REQ-029 busy SHALL be 1 exactly when the state is RECV or WRITE.
REQ-030 done SHALL be 1 exactly when the state is DONE.
REQ-031 A partial word (fewer than 4 bytes) SHALL never be written.

Reset
REQ-032 Asserting reset at any time, including mid-session or during WRITE, SHALL immediately force state IDLE and drive: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, overrun=0, word_count=0, byte counter=0, assembly register=0.
REQ-033 After reset deasserts, the block SHALL take no action until a start pulse.

Verification
REQ-034 Basic load: start, then bytes 20 08 00 05 -> one wr_en pulse, addr 0, data 32'h20080005, in the cycle after the 4th byte; word_count=1; busy=1.
REQ-035 Halt ends session: load 3 words, then FF FF FF FF -> 4 writes at addr 0, 4, 8, 12, the last with data FFFFFFFF; done=1, busy=0, word_count=4.
REQ-036 Overflow: with MEM_WORDS=4, send 4 non-halt words -> writes at 0..12, then overflow=1 and done=1; further bytes produce no wr_en.
REQ-037 Overrun: assert byte_valid in the WRITE cycle -> overrun=1; the dropped byte does not appear in the next word; the next 4 bytes still form a correct word at addr+4.
REQ-038 Reset mid-word: after 2 bytes, pulse reset -> all outputs 0; a new start plus 4 bytes gives a write at addr 0 with only the new bytes.
REQ-039 Restart: after done, start plus 4 bytes -> write at addr 0, done=0, word_count=1; a start pulse while busy leaves the address sequence unchanged.
